load_unit: RTL
==============

// Module: load_unit
// PURPOSE
//  Parametrised successor to the single-shot load return op: issues pipelined memory reads,
//  tracks up to RespDepth outstanding loads over a fixed LoadLatency, and buffers returns in a
//  response FIFO with valid/ready backpressure. Sits between the datapath scheduler and a
//  fixed-latency synchronous memory port.
// PARAMETERS
//  DataWidth    32  memory/response data width; multiple of 8, >= 16
//  AddrWidth    32  byte address width
//  LoadLatency  1   cycles from mem_re to valid mem_rdata; legal 1..LOAD_MAX_LATENCY (8)
//  RespDepth    4   response FIFO entries = max loads in flight + buffered; power of 2, >= 2
// PORTS
//  clk          in   1                      clock, rising edge
//  rst_n        in   1                      asynchronous active-low reset
//  req_valid    in   1                      load request valid
//  req_ready    out  1                      request accepted when req_valid & req_ready
//  req_addr     in   AddrWidth              byte address
//  req_size     in   2                      load_size_e: 0 byte, 1 half, 2 word (3 = word)
//  req_signed   in   1                      1 sign-extend, 0 zero-extend sub-word loads
//  mem_re       out  1                      memory read strobe
//  mem_addr     out  AddrWidth              memory address (= req_addr)
//  mem_rdata    in   DataWidth              read data, valid LoadLatency cycles after mem_re
//  resp_valid   out  1                      response valid
//  resp_ready   in   1                      consumer accepts when resp_valid & resp_ready
//  resp_data    out  DataWidth              response data
//  inflight     out  $clog2(RespDepth+1)    credit count (in flight + buffered)
// BEHAVIOUR
//  - Reset: req_ready=1, mem_re=0, resp_valid=0, resp_data=0, inflight=0; pipeline/FIFO cleared.
//  - Credits: inflight +1 on accept, -1 on pop, unchanged on both same cycle;
//    req_ready = (inflight < RespDepth), registered-count based (no comb path from resp_ready).
//  - Issue: mem_re = req_valid & req_ready (comb); mem_addr = req_addr.
//  - Tag pipeline: LoadLatency-stage shift register carrying {valid, size, signed, byte offset};
//    at stage LoadLatency, extended mem_rdata is pushed into the FIFO. Overflow impossible.
//  - Bypass: if FIFO empty when return lands, resp_valid asserts the same cycle with resp_data
//    comb from mem_rdata (accept->resp latency = LoadLatency). Otherwise from FIFO head.
//    If not popped that cycle, the entry is pushed and held.
//  - Hold: while resp_valid=0, resp_data holds the last delivered value (not X, not 0).
//  - Ordering: strict in-order; back-to-back accepts every cycle sustain full throughput
//    when resp_ready=1 and RespDepth >= LoadLatency+1.
//  - Simultaneous push+pop on full FIFO is legal; pointers wrap modulo RespDepth.
//  - Reset mid-operation: all in-flight loads dropped; mem_rdata arriving after
//    deassertion is ignored.
// CONFIGURATION
//  LOAD_UNIT_EXTEND_EN defined:
//    byte/half lane select by addr[$clog2(DataWidth/8)-1:0]; half ignores addr[0].
//    Sign/zero extension per req_signed.
//  Not defined:
//    req_size/req_signed ignored (ports kept); full mem_rdata returned unmodified.
//    No offset bits in tag pipeline.
// STRUCTURE
//  load_unit_pkg: load_size_e, LOAD_MAX_LATENCY=8, function load_extend(data, size, off, sgn).
//  Sub-module load_resp_fifo (DataWidth x RespDepth, push/pop/empty/full, bypass outside it).
// TESTING
//  1. Single word load, LoadLatency=1, addr 0x10, rdata 0xCAFEBABE, resp_ready=1
//     -> resp_valid 1 cycle after accept, data 0xCAFEBABE, then held with resp_valid=0.
//  2. LoadLatency=3, 8 back-to-back accepts, resp_ready=1 -> 8 in-order responses,
//     one per cycle, first 3 cycles after first accept.
//  3. resp_ready=0, RespDepth=4 -> exactly 4 accepts then req_ready=0; raise resp_ready
//     -> 4 pops in order, req_ready returns 1 the cycle after first pop.
//  4. EXTEND_EN: rdata 0x80FF7F01, byte signed off=3 -> 0xFFFFFF80; half unsigned off=2
//     -> 0x000080FF; byte unsigned off=1 -> 0x0000007F.
//  5. Assert rst_n low with 2 loads in flight, release -> no resp_valid, inflight=0,
//     resp_data=0, late mem_rdata ignored.
//  6. Push and pop same cycle with FIFO full -> inflight unchanged, no data loss or
//     duplication across pointer wrap.

Source files
------------

// File: rtl/load_unit_pkg.sv
// Shared types and helpers for the load unit: access sizes, latency bound and the
// sub-word lane-select/extension function used when LOAD_UNIT_EXTEND_EN is defined.
package load_unit_pkg;

    typedef enum logic [1:0] {
        LOAD_BYTE   = 2'd0,
        LOAD_HALF   = 2'd1,
        LOAD_WORD   = 2'd2,
        LOAD_WORD_W = 2'd3
    } load_size_e;

    localparam int LOAD_MAX_LATENCY = 8;
    localparam int LOAD_MAX_DW      = 256;
    localparam int LOAD_OFF_W       = 5;

    // Picks the addressed byte/half lane and sign- or zero-extends it; word sizes pass through.
    function automatic logic [LOAD_MAX_DW-1:0] load_extend(
        input logic [LOAD_MAX_DW-1:0] data,
        input load_size_e             size,
        input logic [LOAD_OFF_W-1:0]  off,
        input logic                   sgn
    );
        logic [7:0]             byte_v;
        logic [15:0]            half_v;
        logic [LOAD_MAX_DW-1:0] result;
        byte_v = 8'(data >> {off, 3'b000});
        half_v = 16'(data >> {off[LOAD_OFF_W-1:1], 4'b0000});
        case (size)
            LOAD_BYTE: result = {{(LOAD_MAX_DW-8){sgn & byte_v[7]}}, byte_v};
            LOAD_HALF: result = {{(LOAD_MAX_DW-16){sgn & half_v[15]}}, half_v};
            default:   result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_resp_fifo.sv
// Response FIFO for the load unit: DataWidth x Depth circular buffer with
// push/pop/empty/full; simultaneous push and pop on a full buffer is allowed.
module load_resp_fifo #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic [DataWidth-1:0] head_data,
    output logic                 empty,
    output logic                 full
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_r [Depth];
    logic [PtrW-1:0]      wr_ptr_r;
    logic [PtrW-1:0]      rd_ptr_r;
    logic [CntW-1:0]      count_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Entry storage; on a full push+pop the slot being written is the one just read out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= {DataWidth{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PtrW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CntW'(1);
                2'b01:   count_r <= count_r - CntW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign empty     = (count_r == CntW'(0));
    assign full      = (count_r == CntW'(Depth));
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/load_unit.sv
// Pipelined fixed-latency load unit with credit flow control and an in-order response FIFO.
// Define LOAD_UNIT_EXTEND_EN to enable sub-word lane select and sign/zero extension.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int LoadLatency = 1,
    parameter int RespDepth   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [AddrWidth-1:0]           req_addr,
    input  logic [1:0]                     req_size,
    input  logic                           req_signed,
    output logic                           mem_re,
    output logic [AddrWidth-1:0]           mem_addr,
    input  logic [DataWidth-1:0]           mem_rdata,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [DataWidth-1:0]           resp_data,
    output logic [$clog2(RespDepth+1)-1:0] inflight
);
    localparam int CntW     = $clog2(RespDepth + 1);
    // Out-of-range latencies are clamped into the supported window.
    localparam int TagDepth = (LoadLatency < 1) ? 1 :
                              (LoadLatency > LOAD_MAX_LATENCY) ? LOAD_MAX_LATENCY : LoadLatency;

    logic                 accept_s;
    logic                 pop_s;
    logic                 ret_valid_s;
    logic [DataWidth-1:0] ret_data_s;
    logic [DataWidth-1:0] head_data_s;
    logic [DataWidth-1:0] cur_data_s;
    logic [DataWidth-1:0] last_data_r;
    logic [CntW-1:0]      inflight_r;
    logic [TagDepth-1:0]  tag_valid_r;
    logic                 fifo_push_s;
    logic                 fifo_pop_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;

    assign req_ready = (inflight_r < CntW'(RespDepth));
    assign accept_s  = req_valid & req_ready;
    assign mem_re    = accept_s;
    assign mem_addr  = req_addr;
    assign inflight  = inflight_r;

    // Credits cover loads in the tag pipeline plus entries waiting in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= {CntW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   inflight_r <= inflight_r + CntW'(1);
                2'b01:   inflight_r <= inflight_r - CntW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Valid tag shift register; a reset drops every load still waiting on memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_r <= {TagDepth{1'b0}};
        end else begin
            tag_valid_r <= TagDepth'({tag_valid_r, accept_s});
        end
    end

    assign ret_valid_s = tag_valid_r[TagDepth-1];

`ifdef LOAD_UNIT_EXTEND_EN
    localparam int OffW = $clog2(DataWidth / 8);

    logic [TagDepth*2-1:0]    tag_size_r;
    logic [TagDepth-1:0]      tag_sgn_r;
    logic [TagDepth*OffW-1:0] tag_off_r;
    logic [LOAD_MAX_DW-1:0]   ext_s;
    logic                     unused_ext_s;

    // Size/sign/offset attributes travel alongside the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_size_r <= {(TagDepth*2){1'b0}};
            tag_sgn_r  <= {TagDepth{1'b0}};
            tag_off_r  <= {(TagDepth*OffW){1'b0}};
        end else begin
            tag_size_r <= (TagDepth*2)'({tag_size_r, req_size});
            tag_sgn_r  <= TagDepth'({tag_sgn_r, req_signed});
            tag_off_r  <= (TagDepth*OffW)'({tag_off_r, req_addr[OffW-1:0]});
        end
    end

    assign ext_s = load_extend(LOAD_MAX_DW'(mem_rdata),
                               load_size_e'(tag_size_r[TagDepth*2-1 -: 2]),
                               LOAD_OFF_W'(tag_off_r[TagDepth*OffW-1 -: OffW]),
                               tag_sgn_r[TagDepth-1]);
    assign ret_data_s   = ext_s[DataWidth-1:0];
    assign unused_ext_s = ^{ext_s[LOAD_MAX_DW-1:DataWidth], fifo_full_s};
`else
    logic unused_cfg_s;

    assign ret_data_s   = mem_rdata;
    assign unused_cfg_s = ^{req_size, req_signed, fifo_full_s};
`endif

    // A return that lands on an empty FIFO and is taken at once bypasses storage.
    assign resp_valid  = ~fifo_empty_s | ret_valid_s;
    assign pop_s       = resp_valid & resp_ready;
    assign fifo_pop_s  = pop_s & ~fifo_empty_s;
    assign fifo_push_s = ret_valid_s & ~(fifo_empty_s & resp_ready);

    load_resp_fifo #(
        .DataWidth (DataWidth),
        .Depth     (RespDepth)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push_s),
        .push_data (ret_data_s),
        .pop       (fifo_pop_s),
        .head_data (head_data_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    // Response data source: FIFO head first, then the bypassed return, else the held value.
    always_comb begin
        cur_data_s = last_data_r;
        if (!fifo_empty_s) begin
            cur_data_s = head_data_s;
        end else if (ret_valid_s) begin
            cur_data_s = ret_data_s;
        end else begin
            cur_data_s = last_data_r;
        end
    end

    assign resp_data = cur_data_s;

    // Remembers the last presented response so resp_data stays stable while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data_r <= {DataWidth{1'b0}};
        end else if (resp_valid) begin
            last_data_r <= cur_data_s;
        end else begin
            last_data_r <= last_data_r;
        end
    end

endmodule
